// File: rtl/mul_pkg.sv
// Shared sizing for the multiplier and its downstream accumulator stage.
// Both blocks derive their widths from the same defaults and functions.
package mul_pkg;

   localparam int C_W_DEF   = 7;
   localparam int ACC_N_DEF = 8;

   // Sum width that holds ACC_N full-scale products without overflow.
   function automatic int calc_s_w(input int c_w, input int acc_n);
      return c_w + $clog2(acc_n);
   endfunction

   // Counter width that can represent ACC_N itself (used as dout_num).
   function automatic int calc_cnt_w(input int acc_n);
      return $clog2(acc_n + 1);
   endfunction

endpackage

// File: rtl/prod_accum_out_slice.sv
// Single-entry valid/ready output register with same-cycle refill, so a
// consumer taking the held word never costs a bubble.
module out_slice
#(
   parameter int W = 14
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_vld,
   input  logic [W-1:0] i_data,
   output logic         o_rdy,
   output logic         o_vld,
   output logic [W-1:0] o_data,
   input  logic         i_rdy
);

   logic         r_vld;
   logic [W-1:0] r_data;
   logic         w_load;

   assign o_rdy  = !r_vld | i_rdy;
   assign w_load = i_vld & o_rdy;
   assign o_vld  = r_vld;
   assign o_data = r_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld  <= 1'b0;
         r_data <= '0;
      end else begin
         r_vld <= w_load | (r_vld & !i_rdy);
         if (w_load) begin
            r_data <= i_data;
         end
      end
   end

endmodule

// File: rtl/prod_accum.sv
// Sums ACC_N consecutive multiplier products (or fewer, on flush) and hands
// each group sum plus its sample count to a valid/ready consumer.
module prod_accum
   import mul_pkg::*;
#(
   parameter  int C_W   = C_W_DEF,
   parameter  int ACC_N = ACC_N_DEF,
   localparam int CNT_W = calc_cnt_w(ACC_N),
   localparam int S_W   = calc_s_w(C_W, ACC_N)
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [C_W-1:0]   din,
   input  logic             din_vld,
   output logic             din_rdy,
   input  logic             flush,
   output logic [S_W-1:0]   dout,
   output logic [CNT_W-1:0] dout_num,
   output logic             dout_vld,
   input  logic             dout_rdy
);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ACC_N);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [S_W-1:0]       r_acc;
   logic [CNT_W-1:0]     r_cnt;
   logic                 w_slice_rdy;
   logic                 w_accept;
   logic                 w_close;
   logic [S_W-1:0]       w_sum;
   logic [CNT_W-1:0]     w_num;
   logic [S_W+CNT_W-1:0] w_out_data;

   assign din_rdy  = w_slice_rdy;
   assign w_accept = din_vld & w_slice_rdy;

   // Sum and count as they stand after this cycle's beat, if any.
   assign w_sum = w_accept ? r_acc + S_W'(din) : r_acc;
   assign w_num = w_accept ? r_cnt + CNT_ONE : r_cnt;

   // A flush is only honoured while the output slot can take the result.
   assign w_close = (w_accept && (w_num == CNT_FULL)) ||
                    (flush && w_slice_rdy && ((r_cnt != '0) || w_accept));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (w_close) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (w_accept) begin
         r_acc <= w_sum;
         r_cnt <= w_num;
      end
   end

   out_slice #(
      .W (S_W + CNT_W)
   ) u_out_slice (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_vld  (w_close),
      .i_data ({w_sum, w_num}),
      .o_rdy  (w_slice_rdy),
      .o_vld  (dout_vld),
      .o_data (w_out_data),
      .i_rdy  (dout_rdy)
   );

   assign {dout, dout_num} = w_out_data;

endmodule

// File: tb/tb_prod_accum.sv
// Directed bench for prod_accum (C_W=7, ACC_N=8): table-driven vectors plus
// hand-written backpressure, back-to-back and mid-group reset sequences.
module tb_prod_accum;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] din;
   logic       din_vld;
   logic       din_rdy;
   logic       flush;
   logic [9:0] dout;
   logic [3:0] dout_num;
   logic       dout_vld;
   logic       dout_rdy;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc_cnt = 0;

   typedef struct {
      logic       vld;
      logic [6:0] din;
      logic       flush;
      logic       rdy;
      logic       e_rdy;
      logic       e_vld;
      logic [9:0] e_dout;
      logic [3:0] e_num;
   } vec_t;

   typedef struct {
      int sum;
      int num;
      int cyc;
   } obs_t;

   vec_t vecs[30];
   obs_t got_q[$];
   int   exp_q[$];

   always #5 clk = ~clk;

   prod_accum dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .din      (din),
      .din_vld  (din_vld),
      .din_rdy  (din_rdy),
      .flush    (flush),
      .dout     (dout),
      .dout_num (dout_num),
      .dout_vld (dout_vld),
      .dout_rdy (dout_rdy)
   );

   // Every completed output handshake, with the cycle it happened in.
   always @(posedge clk) begin
      cyc_cnt <= cyc_cnt + 1;
      if (rst_n && dout_vld && dout_rdy)
         got_q.push_back(obs_t'{sum: int'(dout), num: int'(dout_num), cyc: cyc_cnt});
   end

   function automatic vec_t mk(input int v, input int d, input int f, input int r,
                               input int er, input int ev, input int ed, input int en);
      vec_t t;
      t.vld = v[0]; t.din = 7'(d); t.flush = f[0]; t.rdy = r[0];
      t.e_rdy = er[0]; t.e_vld = ev[0]; t.e_dout = 10'(ed); t.e_num = 4'(en);
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic apply(input int v, input int d, input int f, input int r);
      din_vld  = v[0];
      din      = 7'(d);
      flush    = f[0];
      dout_rdy = r[0];
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int idx;
      int exp_sum;
      int stalls;

      // Vector table: full group of 127s, partial flush, flush on the 8th
      // beat, single-beat flush groups closing back-to-back.
      idx = 0;
      for (int i = 0; i < 8; i++) vecs[idx++] = mk(1, 127, 0, 1, 1, 0, 0, 0);
      vecs[idx++] = mk(0, 0, 0, 1, 1, 1, 1016, 8);
      vecs[idx++] = mk(1, 3, 0, 1, 1, 0, 0, 0);
      vecs[idx++] = mk(1, 5, 0, 1, 1, 0, 0, 0);
      vecs[idx++] = mk(1, 7, 0, 1, 1, 0, 0, 0);
      vecs[idx++] = mk(0, 0, 1, 1, 1, 0, 0, 0);
      vecs[idx++] = mk(0, 0, 1, 1, 1, 1, 15, 3);
      vecs[idx++] = mk(0, 0, 0, 1, 1, 0, 0, 0);
      vecs[idx++] = mk(0, 0, 0, 1, 1, 0, 0, 0);
      for (int i = 0; i < 7; i++) vecs[idx++] = mk(1, 1, 0, 1, 1, 0, 0, 0);
      vecs[idx++] = mk(1, 1, 1, 1, 1, 0, 0, 0);
      vecs[idx++] = mk(0, 0, 0, 1, 1, 1, 8, 8);
      vecs[idx++] = mk(0, 0, 0, 1, 1, 0, 0, 0);
      vecs[idx++] = mk(1, 100, 1, 1, 1, 0, 0, 0);
      vecs[idx++] = mk(1, 50, 1, 1, 1, 1, 100, 1);
      vecs[idx++] = mk(0, 0, 0, 1, 1, 1, 50, 1);
      vecs[idx++] = mk(0, 0, 0, 1, 1, 0, 0, 0);

      // Power-on reset
      din_vld = 1'b0; din = '0; flush = 1'b0; dout_rdy = 1'b1;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_dout_vld", 32'(dout_vld), 0);
      chk("rst_dout", 32'(dout), 0);
      chk("rst_dout_num", 32'(dout_num), 0);
      chk("rst_din_rdy", 32'(din_rdy), 1);
      rst_n = 1'b1;

      for (int i = 0; i < 30; i++) begin
         apply(vecs[i].vld, vecs[i].din, vecs[i].flush, vecs[i].rdy);
         chk($sformatf("vec%0d_din_rdy", i), 32'(din_rdy), 32'(vecs[i].e_rdy));
         chk($sformatf("vec%0d_dout_vld", i), 32'(dout_vld), 32'(vecs[i].e_vld));
         if (vecs[i].e_vld) begin
            chk($sformatf("vec%0d_dout", i), 32'(dout), 32'(vecs[i].e_dout));
            chk($sformatf("vec%0d_dout_num", i), 32'(dout_num), 32'(vecs[i].e_num));
         end
         tick();
      end

      // Backpressure: group 1 (8x10) stalls, group 2 (8x20) then group 3 (30)
      got_q.delete();
      for (int i = 0; i < 8; i++) begin
         apply(1, 10, 0, 0);
         chk("bp_g1_din_rdy", 32'(din_rdy), 1);
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         apply(1, 20, 0, 0);
         chk("bp_stall_din_rdy", 32'(din_rdy), 0);
         chk("bp_stall_dout_vld", 32'(dout_vld), 1);
         chk("bp_stall_dout", 32'(dout), 80);
         chk("bp_stall_dout_num", 32'(dout_num), 8);
         tick();
      end
      apply(1, 20, 0, 1);
      chk("bp_release_din_rdy", 32'(din_rdy), 1);
      tick();
      for (int i = 0; i < 7; i++) begin
         apply(1, 20, 0, 0);
         chk("bp_g2_din_rdy", 32'(din_rdy), 1);
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         apply(1, 30, 0, 0);
         chk("bp_g2_stall_din_rdy", 32'(din_rdy), 0);
         chk("bp_g2_stall_dout", 32'(dout), 160);
         tick();
      end
      apply(1, 30, 0, 1);
      tick();
      apply(0, 0, 1, 1);
      tick();
      apply(0, 0, 0, 1);
      chk("bp_g3_dout", 32'(dout), 30);
      chk("bp_g3_dout_num", 32'(dout_num), 1);
      tick();
      apply(0, 0, 0, 1);
      chk("bp_order_count", 32'(got_q.size()), 3);
      if (got_q.size() == 3) begin
         chk("bp_order_g1", 32'(got_q[0].sum), 80);
         chk("bp_order_g1_num", 32'(got_q[0].num), 8);
         chk("bp_order_g2", 32'(got_q[1].sum), 160);
         chk("bp_order_g2_num", 32'(got_q[1].num), 8);
         chk("bp_order_g3", 32'(got_q[2].sum), 30);
      end

      // Back-to-back: din=k for 24 beats, scoreboard of expected group sums
      got_q.delete();
      exp_q.delete();
      exp_sum = 0;
      stalls  = 0;
      for (int k = 1; k <= 24; k++) begin
         apply(1, k, 0, 1);
         if (!din_rdy) stalls++;
         exp_sum += k;
         if (k % 8 == 0) begin
            exp_q.push_back(exp_sum);
            exp_sum = 0;
         end
         tick();
      end
      apply(0, 0, 0, 1);
      tick();
      tick();
      chk("b2b_stalls", 32'(stalls), 0);
      chk("b2b_count", 32'(got_q.size()), 3);
      if (got_q.size() == 3) begin
         for (int g = 0; g < 3; g++) begin
            chk($sformatf("b2b_sum%0d", g), 32'(got_q[g].sum), 32'(exp_q[g]));
            chk($sformatf("b2b_num%0d", g), 32'(got_q[g].num), 8);
         end
         chk("b2b_spacing01", 32'(got_q[1].cyc - got_q[0].cyc), 8);
         chk("b2b_spacing12", 32'(got_q[2].cyc - got_q[1].cyc), 8);
      end

      // Reset mid-group at cnt=5 discards the partial sum
      got_q.delete();
      for (int i = 0; i < 5; i++) begin
         apply(1, 9, 0, 1);
         tick();
      end
      apply(0, 0, 0, 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_dout_vld", 32'(dout_vld), 0);
      chk("midrst_dout", 32'(dout), 0);
      chk("midrst_dout_num", 32'(dout_num), 0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         apply(1, 1, 0, 1);
         tick();
      end
      chk("midrst_no_emit", 32'(got_q.size()), 0);
      apply(0, 0, 0, 1);
      chk("postrst_dout_vld", 32'(dout_vld), 1);
      chk("postrst_dout", 32'(dout), 8);
      chk("postrst_dout_num", 32'(dout_num), 8);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
